// File: rtl/nios_system_com_led_driver.sv
// rtl/nios_system_com_led_driver.sv - COM LED output stage: PWM brightness plus activity blink on bit changes
// Each bit blinks for FLASH_TICKS ticks after a change, then shows its steady level; all lit LEDs are PWM-dimmed.
module nios_system_com_led_driver #(
    parameter int PRESCALE    = 50000,
    parameter int BLINK_TICKS = 50,
    parameter int FLASH_TICKS = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] brightness,
    output logic       tick,
    output logic [7:0] led_out
);

    localparam logic [23:0] PRESC_MAX  = 24'(PRESCALE - 1);
    localparam logic [15:0] BLINK_MAX  = 16'(BLINK_TICKS - 1);
    localparam logic [15:0] FLASH_LOAD = 16'(FLASH_TICKS);

    logic [23:0] presc_cnt;
    logic [15:0] blink_cnt;
    logic        blink_phase;
    logic [7:0]  pwm_cnt;
    logic [7:0]  data_q;
    logic [15:0] flash_cnt [8];
    logic [7:0]  chg;
    logic [7:0]  flash_act;
    logic        pwm_on;

    always_comb begin
        chg    = data_in ^ data_q;
        pwm_on = (brightness == 8'hff) || (pwm_cnt < brightness);
        for (int i = 0; i < 8; i++) begin
            flash_act[i] = (flash_cnt[i] != 16'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt <= '0;
            tick      <= 1'b0;
        end else if (presc_cnt == PRESC_MAX) begin
            presc_cnt <= '0;
            tick      <= 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 24'd1;
            tick      <= 1'b0;
        end
    end

    // Shared blink phase keeps every flashing LED in step with the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // A fresh change always restarts the window, even on a tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            for (int i = 0; i < 8; i++) begin
                flash_cnt[i] <= '0;
            end
        end else begin
            data_q <= data_in;
            for (int i = 0; i < 8; i++) begin
                if (chg[i]) begin
                    flash_cnt[i] <= FLASH_LOAD;
                end else if (tick && flash_act[i]) begin
                    flash_cnt[i] <= flash_cnt[i] - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
        end else begin
            led_out <= ((flash_act & {8{blink_phase}}) | (~flash_act & data_q)) & {8{pwm_on}};
        end
    end

endmodule
